// File: rtl/pipe_ctrl_pkg.sv
// Shared FSM type and default parameter values for the pipeline controller.
package pipes;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_MWAIT = 1'b1
   } pipe_state_t;

   localparam int NSTAGE_DEF    = 5;
   localparam int HAZ_STAGE_DEF = 1;
   localparam int RED_STAGE_DEF = 2;
   localparam int CNT_W_DEF     = 64;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for pipe_ctrl; the module only exists when
// PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf
   import pipes::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit,
   input  logic             stall,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   // All three counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (commit) instret_cnt <= instret_cnt + CNT_W'(1);
         if (stall)  stall_cnt   <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// In-order pipeline stall/flush controller. Define PIPE_CTRL_PERF_EN to
// build the cycle/instret/stall counters; otherwise they read as zero.
module pipe_ctrl
   import pipes::*;
#(
   parameter int NSTAGE    = NSTAGE_DEF,
   parameter int HAZ_STAGE = HAZ_STAGE_DEF,
   parameter int RED_STAGE = RED_STAGE_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              imem_ok,
   input  logic              dmem_busy,
   input  logic              redirect,
   input  logic              load_use,
   output logic              pc_en,
   output logic              pc_sel_red,
   output logic [NSTAGE-1:0] stage_en,
   output logic [NSTAGE-1:0] stage_valid,
   output logic              commit,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  instret_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   pipe_state_t       state, state_nxt;
   logic              red_pend;
   logic              red_now;
   logic [NSTAGE-1:0] kill;
   logic [NSTAGE-1:0] shifted;
   logic [NSTAGE-1:0] valid_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= S_RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN:   if (dmem_busy)  state_nxt = S_MWAIT;
         S_MWAIT: if (!dmem_busy) state_nxt = S_RUN;
         default: state_nxt = S_RUN;
      endcase
   end

   // A redirect seen while busy is parked until the memory stall ends.
   always_ff @(posedge clk) begin
      if (reset) red_pend <= 1'b0;
      else       red_pend <= dmem_busy ? (red_pend | redirect) : 1'b0;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the priority chain can leave a latch behind.
   always_comb begin
      red_now    = redirect;
      pc_en      = 1'b0;
      pc_sel_red = 1'b0;
      stage_en   = '0;
      kill       = '0;
      case (state)
         S_RUN:   red_now = redirect;
         S_MWAIT: red_now = redirect | red_pend;
         default: red_now = redirect;
      endcase
      if (reset || dmem_busy) begin
         pc_en = 1'b0;
      end else if (red_now) begin
         pc_en      = 1'b1;
         pc_sel_red = 1'b1;
         stage_en   = '1;
         for (int i = 0; i < NSTAGE; i++) begin
            if (i < RED_STAGE) kill[i] = 1'b1;
         end
      end else if (load_use) begin
         for (int i = 0; i < NSTAGE; i++) begin
            stage_en[i] = (i > HAZ_STAGE);
         end
         kill[HAZ_STAGE+1] = 1'b1;
      end else if (!imem_ok) begin
         stage_en = '1;
         kill[0]  = 1'b1;
      end else begin
         pc_en    = 1'b1;
         stage_en = '1;
      end
   end

   // The fetch register always sees a valid instruction; bubbles come from kill.
   assign shifted   = {stage_valid[NSTAGE-2:0], 1'b1};
   assign valid_nxt = (stage_en & shifted & ~kill) | (~stage_en & stage_valid);

   always_ff @(posedge clk) begin
      if (reset) stage_valid <= '0;
      else       stage_valid <= valid_nxt;
   end

   assign commit = stage_valid[NSTAGE-1] & stage_en[NSTAGE-1];

`ifdef PIPE_CTRL_PERF_EN
   logic stall;
   assign stall = (state == S_MWAIT) | (!dmem_busy & !red_now & load_use);

   pipe_perf #(
      .CNT_W(CNT_W)
   ) u_perf (
      .clk        (clk),
      .reset      (reset),
      .commit     (commit),
      .stall      (stall),
      .cycle_cnt  (cycle_cnt),
      .instret_cnt(instret_cnt),
      .stall_cnt  (stall_cnt)
   );
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
   assign stall_cnt   = '0;
`endif

endmodule
